router_fsm: RTL

- Sequencing controller for the 1x3 router packet-receive path.
- Watches the incoming byte stream (pkt_valid, address bits), the selected FIFO's full/empty flags and the per-port soft-reset timeouts.
- Drives the strobes that tell the register block and the synchroniser when to latch the address, load header/payload/parity, stall, and check parity.
- Moore machine: every output is decoded from the current state only.

---
 rtl/router_fsm.sv | 127 ++++++++++++
 1 files changed

// File: rtl/router_fsm.sv
// ============================================================================
// router_fsm : packet-receive sequencing controller for the 1x3 router
// Revision   : 1.0
// ============================================================================
`default_nettype none

module router_fsm #(
  parameter logic [1:0] ADDR_INVALID = 2'b11
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       pkt_valid,
  input  logic [1:0] data_in,
  input  logic       fifo_full,
  input  logic       fifo_empty_0,
  input  logic       fifo_empty_1,
  input  logic       fifo_empty_2,
  input  logic       soft_reset_0,
  input  logic       soft_reset_1,
  input  logic       soft_reset_2,
  input  logic       parity_done,
  input  logic       low_pkt_valid,
  output logic       detect_add,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       laf_state,
  output logic       full_state,
  output logic       write_enb_reg,
  output logic       rst_int_reg,
  output logic       busy
);

  typedef enum logic [2:0] {
    DA  = 3'd0,
    LFD = 3'd1,
    LD  = 3'd2,
    FFS = 3'd3,
    LAF = 3'd4,
    LP  = 3'd5,
    CPE = 3'd6,
    WTE = 3'd7
  } state_t;

  state_t     state, next_state;
  logic [1:0] addr;
  logic [1:0] addr_mux;
  logic       sel_empty;
  logic       sel_soft;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= DA;
      addr  <= 2'b00;
    end else begin
      state <= next_state;
      if (state == DA && pkt_valid)
        addr <= data_in;
    end
  end

  // Live header bits are only meaningful while decoding; afterwards the latched address selects the port.
  always_comb begin
    addr_mux  = (state == DA) ? data_in : addr;
    sel_empty = 1'b0;
    sel_soft  = 1'b0;
    case (addr_mux)
      2'd0:    begin sel_empty = fifo_empty_0; sel_soft = soft_reset_0; end
      2'd1:    begin sel_empty = fifo_empty_1; sel_soft = soft_reset_1; end
      2'd2:    begin sel_empty = fifo_empty_2; sel_soft = soft_reset_2; end
      default: begin sel_empty = 1'b0;         sel_soft = 1'b0;         end
    endcase
  end

  always_comb begin
    next_state = state;
    if (state != DA && sel_soft) begin
      next_state = DA;
    end else begin
      case (state)
        DA: begin
          if (pkt_valid && data_in != ADDR_INVALID)
            next_state = sel_empty ? LFD : WTE;
        end
        LFD: next_state = LD;
        LD: begin
          if (fifo_full)       next_state = FFS;
          else if (!pkt_valid) next_state = LP;
        end
        FFS: if (!fifo_full) next_state = LAF;
        LAF: begin
          if (parity_done)        next_state = DA;
          else if (low_pkt_valid) next_state = LP;
          else                    next_state = LD;
        end
        LP:      next_state = CPE;
        CPE:     next_state = fifo_full ? FFS : DA;
        WTE:     if (sel_empty) next_state = LFD;
        default: next_state = DA;
      endcase
    end
  end

  always_comb begin
    detect_add    = 1'b0;
    lfd_state     = 1'b0;
    ld_state      = 1'b0;
    laf_state     = 1'b0;
    full_state    = 1'b0;
    write_enb_reg = 1'b0;
    rst_int_reg   = 1'b0;
    busy          = 1'b0;
    case (state)
      DA:  detect_add = 1'b1;
      LFD: begin lfd_state = 1'b1; busy = 1'b1; end
      LD:  begin ld_state = 1'b1; write_enb_reg = 1'b1; end
      FFS: begin full_state = 1'b1; busy = 1'b1; end
      LAF: begin laf_state = 1'b1; write_enb_reg = 1'b1; busy = 1'b1; end
      LP:  begin write_enb_reg = 1'b1; busy = 1'b1; end
      CPE: begin rst_int_reg = 1'b1; busy = 1'b1; end
      WTE: busy = 1'b1;
      default: ;
    endcase
  end

endmodule

`default_nettype wire
